sbus_frame_decoder: RTL

Sits directly downstream of the S.BUS receive timing stage. It takes the raw rx line together with that stage's per-bit sample strobe and frame-start pulse. It assembles 25 serial bytes (8E2 framing), validates each frame, and unpacks the 16 proportional channels of 11 bits plus the digital and status flags. Register outputs update atomically only on a fully valid frame and feed the PD control loop.

---
 rtl/sbus_frame_decoder.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sbus_frame_decoder.sv
// S.BUS frame decoder: assembles 25 8E2 bytes, validates the frame and
// unpacks 16x11-bit channels plus flags, committing only whole good frames.
module sbus_frame_decoder #(
  parameter logic [7:0] HEADER = 8'h0F,
  parameter logic [7:0] FOOTER = 8'h00,
  parameter int         ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic             sample,
  input  logic             frame_sync,
  input  logic [3:0]       ch_sel,
  output logic [10:0]      ch_value,
  output logic             ch17,
  output logic             ch18,
  output logic             frame_lost,
  output logic             failsafe,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK
  } state_e;

  state_e             state_q, state_d;
  logic [4:0]         byte_idx_q, byte_idx_d;
  logic [3:0]         bit_idx_q, bit_idx_d;
  logic [11:0]        shreg_q, shreg_d;
  logic               bad_q, bad_d;
  logic [18:0]        acc_q, acc_d;
  logic [4:0]         n_q, n_d;
  logic [4:0]         k_q, k_d;
  logic [15:0][10:0]  sh_ch_q, sh_ch_d;
  logic [3:0]         sh_flg_q, sh_flg_d;
  logic [15:0][10:0]  ch_q, ch_d;
  logic [3:0]         flg_q, flg_d;
  logic               fv_q, fv_d;
  logic               fe_q, fe_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic [11:0] byte_nx;
  logic [7:0]  data;
  logic        byte_bad;
  logic        bad_now;
  logic        bad_fin;
  logic [18:0] acc_or;
  logic [4:0]  n_sum;
  logic        restart;
  logic        count_err;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    bad_d      = bad_q;
    acc_d      = acc_q;
    n_d        = n_q;
    k_d        = k_q;
    sh_ch_d    = sh_ch_q;
    sh_flg_d   = sh_flg_q;
    ch_d       = ch_q;
    flg_d      = flg_q;
    fv_d       = 1'b0;
    fe_d       = 1'b0;
    err_d      = err_q;
    restart    = 1'b0;
    count_err  = 1'b0;

    // Byte as it stands once the current bit is shifted in (LSB first).
    byte_nx  = {rx, shreg_q[11:1]};
    data     = byte_nx[8:1];
    byte_bad = byte_nx[0] | ~(&byte_nx[11:10]) | (^byte_nx[9:1]);
    bad_now  = bad_q | byte_bad;
    bad_fin  = bad_now | (data != FOOTER) |
               (n_q != 5'd0) | (k_q != 5'd16);
    acc_or   = acc_q | (19'(data) << n_q);
    n_sum    = n_q + 5'd8;

    unique case (state_q)
      IDLE: restart = frame_sync;
      RECV: begin
        if (frame_sync) begin
          restart = 1'b1;
          if (byte_idx_q != 5'd0 || bit_idx_q != 4'd0) begin
            fe_d      = 1'b1;
            count_err = 1'b1;
          end
        end else if (sample) begin
          shreg_d   = byte_nx;
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd11) begin
            bit_idx_d  = 4'd0;
            byte_idx_d = byte_idx_q + 5'd1;
            bad_d      = bad_now;
            unique case (1'b1)
              (byte_idx_q == 5'd0):
                bad_d = bad_now | (data != HEADER);
              (byte_idx_q inside {[5'd1:5'd22]}): begin
                acc_d = acc_or;
                n_d   = n_sum;
                if (n_sum >= 5'd11) begin
                  if (!k_q[4]) sh_ch_d[k_q[3:0]] = acc_or[10:0];
                  k_d   = k_q + 5'd1;
                  acc_d = acc_or >> 11;
                  n_d   = n_sum - 5'd11;
                end
              end
              (byte_idx_q == 5'd23):
                sh_flg_d = data[3:0];
              (byte_idx_q == 5'd24): begin
                state_d = CHECK;
                bad_d   = bad_fin;
                if (bad_fin) begin
                  fe_d      = 1'b1;
                  count_err = 1'b1;
                end else begin
                  fv_d  = 1'b1;
                  ch_d  = sh_ch_q;
                  flg_d = sh_flg_q;
                end
              end
              default: ;
            endcase
          end
        end
      end
      CHECK: begin
        // Verdict was applied on entry; this cycle carries the pulse.
        state_d = IDLE;
        restart = frame_sync;
      end
      default: state_d = IDLE;
    endcase

    if (count_err && err_q != {ERR_W{1'b1}})
      err_d = err_q + ERR_W'(1);

    if (restart) begin
      state_d    = RECV;
      byte_idx_d = 5'd0;
      bit_idx_d  = 4'd1;
      shreg_d    = {rx, 11'd0};
      bad_d      = 1'b0;
      acc_d      = '0;
      n_d        = 5'd0;
      k_d        = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      bad_q      <= 1'b0;
      acc_q      <= '0;
      n_q        <= '0;
      k_q        <= '0;
      sh_ch_q    <= '0;
      sh_flg_q   <= '0;
      ch_q       <= '0;
      flg_q      <= '0;
      fv_q       <= 1'b0;
      fe_q       <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      bad_q      <= bad_d;
      acc_q      <= acc_d;
      n_q        <= n_d;
      k_q        <= k_d;
      sh_ch_q    <= sh_ch_d;
      sh_flg_q   <= sh_flg_d;
      ch_q       <= ch_d;
      flg_q      <= flg_d;
      fv_q       <= fv_d;
      fe_q       <= fe_d;
      err_q      <= err_d;
    end
  end

  assign ch_value    = ch_q[ch_sel];
  assign ch17        = flg_q[0];
  assign ch18        = flg_q[1];
  assign frame_lost  = flg_q[2];
  assign failsafe    = flg_q[3];
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign err_cnt     = err_q;
  assign busy        = (state_q != IDLE);

endmodule
